// File: rtl/button_request_arbiter_pkg.sv
// ============================================================================
//  Module   : button_request_arbiter_pkg
//  Brief    : Shared state encodings and default sizing for the pushbutton
//             request arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_request_arbiter_pkg;

  // Arbiter controller states; encoding 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_SELECT = 2'b01,
    ARB_ISSUE  = 2'b10
  } arb_state_t;

  // Default channel count and matching grant-index width.
  localparam int ARB_NUM_REQ_DEFAULT = 4;
  localparam int ARB_IDX_W_DEFAULT   = 2;

endpackage : button_request_arbiter_pkg

`default_nettype wire

// File: rtl/button_request_arbiter_rr_pick.sv
// ============================================================================
//  Module   : button_request_arbiter_rr_pick
//  Brief    : Combinational winner selection over the pending vector.
//             Default build: round-robin, first set bit at or after rr_ptr,
//             wrapping to the lowest set bit below it.
//             Build macro ARB_FIXED_PRIORITY_EN: lowest-index set bit wins
//             and rr_ptr is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_request_arbiter_rr_pick
  import button_request_arbiter_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEFAULT,
  parameter int IDX_W   = ARB_IDX_W_DEFAULT
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_pending
);

  assign any_pending = |pending;

`ifdef ARB_FIXED_PRIORITY_EN

  // Pointer is irrelevant for fixed priority; folded into a sink signal.
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  // Lowest-index pending channel wins (descending scan, last hit is lowest).
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending[i]) winner = IDX_W'(i);
    end
  end

`else

  logic [IDX_W-1:0] winner_hi;
  logic [IDX_W-1:0] winner_lo;
  logic             found_hi;

  // Round-robin: lowest set bit at/above the pointer, else wrap to lowest overall.
  always_comb begin
    winner_hi = '0;
    winner_lo = '0;
    found_hi  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending[i]) winner_lo = IDX_W'(i);
      if (pending[i] && (IDX_W'(i) >= rr_ptr)) begin
        winner_hi = IDX_W'(i);
        found_hi  = 1'b1;
      end
    end
    winner = found_hi ? winner_hi : winner_lo;
  end

`endif

endmodule : button_request_arbiter_rr_pick

`default_nettype wire

// File: rtl/button_request_arbiter.sv
// ============================================================================
//  Module   : button_request_arbiter
//  Brief    : Latches one-cycle pushbutton pulses as pending requests and
//             issues one grant at a time over a valid/ready handshake.
//             IDLE -> SELECT (register winner, clear its pending bit) ->
//             ISSUE (grant_valid until grant_ready).
//             Build macro ARB_FIXED_PRIORITY_EN selects fixed lowest-index
//             priority and holds rr_ptr at zero; ports and timing unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_request_arbiter
  import button_request_arbiter_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEFAULT,
  parameter int IDX_W   = ARB_IDX_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_pulse,
  input  logic               grant_ready,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] pending,
  output logic               busy,
  output logic               overflow
);

  arb_state_t         state;
  arb_state_t         state_next;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_ptr_next;
  logic [IDX_W-1:0]   grant_idx_next;
  logic [IDX_W-1:0]   winner;
  logic               any_pending;
  logic [NUM_REQ-1:0] clear_vec;
  logic [NUM_REQ-1:0] pending_next;
  logic               overflow_set;

  button_request_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .winner      (winner),
    .any_pending (any_pending)
  );

  // Pending update: winner cleared on SELECT->ISSUE, new pulses set (set wins).
  always_comb begin
    clear_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      clear_vec[i] = (state == ARB_SELECT) && (winner == IDX_W'(i));
    end
    pending_next = (pending & ~clear_vec) | req_pulse;
    overflow_set = |(req_pulse & pending & ~clear_vec);
  end

  // Next-state, pointer advance and Moore outputs.
  always_comb begin
    state_next     = state;
    rr_ptr_next    = rr_ptr;
    grant_idx_next = grant_idx;
    grant_valid    = 1'b0;
    busy           = 1'b1;
    case (state)
      ARB_IDLE: begin
        busy = 1'b0;
        if (any_pending) state_next = ARB_SELECT;
      end
      ARB_SELECT: begin
        grant_idx_next = winner;
        state_next     = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        grant_valid = 1'b1;
        if (grant_ready) begin
`ifdef ARB_FIXED_PRIORITY_EN
          rr_ptr_next = '0;
`else
          rr_ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
          state_next  = (|pending_next) ? ARB_SELECT : ARB_IDLE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_next;
  end

  // Datapath registers: pending set, pointer, granted index, sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending   <= '0;
      rr_ptr    <= '0;
      grant_idx <= '0;
      overflow  <= 1'b0;
    end else begin
      pending   <= pending_next;
      rr_ptr    <= rr_ptr_next;
      grant_idx <= grant_idx_next;
      if (overflow_set) overflow <= 1'b1;
    end
  end

endmodule : button_request_arbiter

`default_nettype wire
